// File: rtl/xbus_decoder_if.sv
// Master-side data bus between the CPU bridge and the xbus decoder.
// The decoder sits on the slave modport; the bridge or bench drives the master modport.
interface xbus_decoder_if;
  logic        XDREQ;
  logic [31:0] XADDR;
  logic        XWR;
  logic [31:0] XATAO;
  logic        XDACK;
  logic        XERR;

  modport master (
    output XDREQ, XADDR, XWR,
    input  XATAO, XDACK, XERR
  );

  modport slave (
    input  XDREQ, XADDR, XWR,
    output XATAO, XDACK, XERR
  );
endinterface

// File: rtl/xbus_decoder.sv
// Address decoder and response mux from the CPU bridge bus to NSLV slaves, with
// internal answers for unmapped selects, per-access timeout and an error record.
module xbus_decoder #(
  parameter int unsigned NSLV    = 4,
  parameter int unsigned SELB    = 2,
  parameter int unsigned TMO     = 15,
  parameter logic [31:0] DEFDATA = 32'hdeadbeef
) (
  input  logic                 CLK,
  input  logic                 RES,
  xbus_decoder_if.slave        xbus,
  output logic [NSLV-1:0]      SDREQ,
  input  logic [32*NSLV-1:0]   SATAI,
  input  logic [NSLV-1:0]      SDACK,
  input  logic                 ERRCLR,
  output logic [31:0]          ERRADDR,
  output logic                 ERRWR,
  output logic [7:0]           ERRCNT
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [SELB-1:0] r_sel;
  logic [7:0]      r_tcnt;
  logic [31:0]     r_addr;
  logic            r_wr;

  logic [SELB-1:0] w_sel_in;
  logic            w_mapped;
  logic            w_ack;
  logic [31:0]     w_rdata;
  logic            w_timeout;

  assign w_sel_in  = xbus.XADDR[31 -: SELB];
  assign w_mapped  = (32'(w_sel_in) < NSLV);
  assign w_timeout = (r_tcnt == 8'(TMO - 1));

  // Only the registered selected slave is observed; other acks and data are ignored.
  always_comb begin
    w_ack   = 1'b0;
    w_rdata = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (32'(r_sel) == i) begin
        w_ack   = SDACK[i];
        w_rdata = SATAI[32*i +: 32];
      end
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (xbus.XDREQ) w_next = w_mapped ? S_BUSY : S_ERR;
      S_BUSY: begin
        // Master abort beats everything; an ack on the last allowed cycle beats the timeout.
        if (!xbus.XDREQ)    w_next = S_IDLE;
        else if (w_ack)     w_next = S_DONE;
        else if (w_timeout) w_next = S_ERR;
      end
      S_ERR:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    SDREQ      = '0;
    xbus.XDACK = 1'b0;
    xbus.XERR  = 1'b0;
    xbus.XATAO = '0;
    case (r_state)
      S_BUSY: begin
        for (int unsigned i = 0; i < NSLV; i++)
          SDREQ[i] = xbus.XDREQ && (32'(r_sel) == i);
        xbus.XDACK = w_ack && xbus.XDREQ;
        xbus.XATAO = w_rdata;
      end
      S_ERR: begin
        xbus.XDACK = 1'b1;
        xbus.XERR  = 1'b1;
        xbus.XATAO = DEFDATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_sel  <= '0;
      r_addr <= '0;
      r_wr   <= 1'b0;
      r_tcnt <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        r_tcnt <= '0;
        if (xbus.XDREQ) begin
          r_sel  <= w_sel_in;
          r_addr <= xbus.XADDR;
          r_wr   <= xbus.XWR;
        end
      end else if (r_state == S_BUSY) begin
        r_tcnt <= r_tcnt + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      ERRADDR <= '0;
      ERRWR   <= 1'b0;
      ERRCNT  <= '0;
    end else begin
      if (r_state == S_ERR) begin
        ERRADDR <= r_addr;
        ERRWR   <= r_wr;
      end
      if (ERRCLR)
        ERRCNT <= '0;
      else if (r_state == S_ERR && ERRCNT != 8'hff)
        ERRCNT <= ERRCNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_xbus_decoder.sv
// Directed bench for xbus_decoder: mapped read, unmapped select, timeout with late ack,
// ack on the last allowed cycle, error-count saturation/clear, and reset mid-access.
module tb_xbus_decoder;
  localparam int unsigned NSLV = 3;

  logic              CLK = 1'b0;
  logic              RES = 1'b0;
  logic [NSLV-1:0]   SDREQ;
  logic [NSLV-1:0]   SDACK = '0;
  logic [32*NSLV-1:0] SATAI = '0;
  logic              ERRCLR = 1'b0;
  logic [31:0]       ERRADDR;
  logic              ERRWR;
  logic [7:0]        ERRCNT;

  int n_cmp = 0;
  int n_bad = 0;

  xbus_decoder_if bus ();

  xbus_decoder #(
    .NSLV   (NSLV),
    .SELB   (2),
    .TMO    (15),
    .DEFDATA(32'hdeadbeef)
  ) dut (
    .CLK    (CLK),
    .RES    (RES),
    .xbus   (bus),
    .SDREQ  (SDREQ),
    .SATAI  (SATAI),
    .SDACK  (SDACK),
    .ERRCLR (ERRCLR),
    .ERRADDR(ERRADDR),
    .ERRWR  (ERRWR),
    .ERRCNT (ERRCNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  // One unmapped access: request cycle, ERR cycle (optional ERRCLR), DONE cycle.
  task automatic unmapped_access(input logic clr);
    step;
    bus.XDREQ = 1'b1; bus.XADDR = 32'hC000_0004; bus.XWR = 1'b0;
    step;
    ERRCLR = clr;
    settle;
    chk("unm_loop_ack", {bus.XDACK, bus.XERR}, 2'b11);
    step;
    bus.XDREQ = 1'b0; ERRCLR = 1'b0;
  endtask

  initial begin
    bus.XDREQ = 1'b0; bus.XADDR = '0; bus.XWR = 1'b0;

    // Reset state
    #3;
    chk("rst_sdreq", SDREQ, 3'b000);
    chk("rst_xdack", bus.XDACK, 1'b0);
    chk("rst_xerr", bus.XERR, 1'b0);
    chk("rst_xatao", bus.XATAO, 32'h0);
    chk("rst_erraddr", ERRADDR, 32'h0);
    chk("rst_errwr", ERRWR, 1'b0);
    chk("rst_errcnt", ERRCNT, 8'h0);
    step; step;
    RES = 1'b1;

    // Mapped read to slave 1, ack 3 cycles after SDREQ
    step;
    bus.XDREQ = 1'b1; bus.XADDR = 32'h4000_0010; bus.XWR = 1'b0;
    settle;
    chk("m_c0_sdreq", SDREQ, 3'b000);
    step; settle;
    chk("m_c1_sdreq", SDREQ, 3'b010);
    chk("m_c1_xdack", bus.XDACK, 1'b0);
    step; settle;
    chk("m_c2_xdack", bus.XDACK, 1'b0);
    step;
    SDACK = 3'b001; // non-selected slave ack is ignored
    settle;
    chk("m_c3_other_ack", bus.XDACK, 1'b0);
    chk("m_c3_sdreq", SDREQ, 3'b010);
    step;
    SDACK = 3'b010; SATAI[63:32] = 32'h1234_5678;
    settle;
    chk("m_c4_xdack", bus.XDACK, 1'b1);
    chk("m_c4_xatao", bus.XATAO, 32'h1234_5678);
    chk("m_c4_xerr", bus.XERR, 1'b0);
    step;
    bus.XDREQ = 1'b0; SDACK = '0;
    settle;
    chk("m_done_xdack", bus.XDACK, 1'b0);
    chk("m_done_xatao", bus.XATAO, 32'h0);
    chk("m_done_sdreq", SDREQ, 3'b000);
    step;

    // Unmapped select 3 with NSLV=3
    step;
    bus.XDREQ = 1'b1; bus.XADDR = 32'hC000_0000; bus.XWR = 1'b0;
    step; settle;
    chk("u_c1_xdack", bus.XDACK, 1'b1);
    chk("u_c1_xerr", bus.XERR, 1'b1);
    chk("u_c1_xatao", bus.XATAO, 32'hdeadbeef);
    chk("u_c1_sdreq", SDREQ, 3'b000);
    step;
    bus.XDREQ = 1'b0;
    settle;
    chk("u_erraddr", ERRADDR, 32'hC000_0000);
    chk("u_errcnt", ERRCNT, 8'd1);
    chk("u_errwr", ERRWR, 1'b0);
    step;

    // Timeout: write to slave 2 that never acks
    step;
    bus.XDREQ = 1'b1; bus.XADDR = 32'h8000_0020; bus.XWR = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step; settle;
      chk("t_sdreq", SDREQ, 3'b100);
      chk("t_noack", bus.XDACK, 1'b0);
    end
    step; settle;
    chk("t_c16_ackerr", {bus.XDACK, bus.XERR}, 2'b11);
    chk("t_c16_sdreq", SDREQ, 3'b000);
    chk("t_c16_xatao", bus.XATAO, 32'hdeadbeef);
    step;
    bus.XDREQ = 1'b0; bus.XWR = 1'b0;
    settle;
    chk("t_errwr", ERRWR, 1'b1);
    chk("t_errcnt", ERRCNT, 8'd2);
    chk("t_erraddr", ERRADDR, 32'h8000_0020);
    step;
    step;
    SDACK = 3'b100; SATAI[95:64] = 32'hFFFF_0000;
    settle;
    chk("t_late_ack", bus.XDACK, 1'b0);
    chk("t_late_xatao", bus.XATAO, 32'h0);
    step;
    SDACK = '0;

    // Slave 0 acks on the 15th (last allowed) BUSY cycle
    step;
    bus.XDREQ = 1'b1; bus.XADDR = 32'h0000_0100; bus.XWR = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      step; settle;
      chk("e_wait_sdreq", SDREQ, 3'b001);
    end
    step;
    SDACK = 3'b001; SATAI[31:0] = 32'hA5A5_0001;
    settle;
    chk("e_c15_xdack", bus.XDACK, 1'b1);
    chk("e_c15_xerr", bus.XERR, 1'b0);
    chk("e_c15_xatao", bus.XATAO, 32'hA5A5_0001);
    step;
    bus.XDREQ = 1'b0; SDACK = '0;
    settle;
    chk("e_done_xdack", bus.XDACK, 1'b0);
    chk("e_errcnt", ERRCNT, 8'd2);
    step;

    // ERRCLR alone, then saturation and coincident clear
    step;
    ERRCLR = 1'b1;
    step;
    ERRCLR = 1'b0;
    settle;
    chk("c_clr", ERRCNT, 8'd0);
    for (int n = 0; n < 255; n++) unmapped_access(1'b0);
    settle;
    chk("c_255", ERRCNT, 8'd255);
    unmapped_access(1'b0);
    settle;
    chk("c_256_sat", ERRCNT, 8'd255);
    chk("c_erraddr", ERRADDR, 32'hC000_0004);
    unmapped_access(1'b1);
    settle;
    chk("c_257_clr", ERRCNT, 8'd0);

    // Reset asserted in BUSY cycle 5, then a fresh slave 0 access
    step;
    step;
    bus.XDREQ = 1'b1; bus.XADDR = 32'h4000_0000; bus.XWR = 1'b0;
    for (int c = 1; c <= 5; c++) step;
    settle;
    chk("r_pre_sdreq", SDREQ, 3'b010);
    RES = 1'b0;
    #1;
    chk("r_sdreq", SDREQ, 3'b000);
    chk("r_xdack", bus.XDACK, 1'b0);
    chk("r_erraddr", ERRADDR, 32'h0);
    bus.XDREQ = 1'b0;
    step; step;
    RES = 1'b1;
    step;
    bus.XDREQ = 1'b1; bus.XADDR = 32'h0000_0000;
    step;
    SDACK = 3'b001; SATAI[31:0] = 32'h0000_C0DE;
    settle;
    chk("r_new_sdreq", SDREQ, 3'b001);
    chk("r_new_xdack", bus.XDACK, 1'b1);
    chk("r_new_xerr", bus.XERR, 1'b0);
    chk("r_new_xatao", bus.XATAO, 32'h0000_C0DE);
    step;
    bus.XDREQ = 1'b0; SDACK = '0;
    settle;
    chk("r_new_done", bus.XDACK, 1'b0);
    step;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
